block_lock_67: RTL and testbench

//  64b/67b block-lock and payload-recovery stage fed by the 40->67 RX gearbox.
//  - Checks the framing bits [65:64] of each 67-bit word.
//  - Drives the gearbox slip request until framing is found, then declares lock and monitors the error rate.
//  - Delivers 64-bit payload words plus control flag and error flag to the descrambler/deframer.

---
 rtl/block_lock_67.sv | 171 +++++++++++++++++
 tb/tb_block_lock_67.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_lock_67.sv
// block_lock_67: 64b/67b block lock and payload recovery behind the 40->67 RX gearbox.
// Hunts for framing by letting the gearbox slip on bad headers. It declares lock after
// LOCK_CNT consecutive good headers, then drops lock when ERR_MAX bad headers land
// within one ERR_WIN-word window.
// Optional feature: define BLOCK_LOCK_67_INVERT_EN to honour din[66] (payload inverted
// in the output register). When it is undefined, din[66] is ignored.
//
// state | meaning
// HUNT  | searching for framing, gearbox slip permitted, counting consecutive good headers
// BLANK | bad header seen, ignoring SLIP_BLANK valid words while the gearbox slip settles
// LOCK  | block lock held, payload delivered, error rate monitored per window
module block_lock_67 #(
   parameter int LOCK_CNT   = 64,
   parameter int SLIP_BLANK = 4,
   parameter int ERR_WIN    = 64,
   parameter int ERR_MAX    = 16
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic [66:0] din,
   input  logic        din_valid,
   output logic        slip_to_frame,
   output logic        locked,
   output logic [63:0] dout,
   output logic        dout_ctl,
   output logic        dout_err,
   output logic        dout_valid
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(SLIP_BLANK + 1);
   localparam int WW = $clog2(ERR_WIN + 1);
   localparam int EW = $clog2(ERR_MAX + 1);

   localparam logic [GW-1:0] LOCK_C  = GW'(LOCK_CNT);
   localparam logic [BW-1:0] BLANK_C = BW'(SLIP_BLANK);
   localparam logic [WW-1:0] WIN_C   = WW'(ERR_WIN);
   localparam logic [EW-1:0] EMAX_C  = EW'(ERR_MAX);

   typedef enum logic [1:0] {HUNT, BLANK, LOCK} state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] gcnt_q, gcnt_d, gcnt_inc;
   logic [BW-1:0] bcnt_q, bcnt_d, bcnt_inc;
   logic [WW-1:0] wcnt_q, wcnt_d, wcnt_inc;
   logic [EW-1:0] ecnt_q, ecnt_d, ecnt_inc;
   logic          slip_q, locked_q;
   logic [63:0]   dout_q, dout_d, payload;
   logic          ctl_q, ctl_d, err_q, err_d, dv_q, dv_d;
   logic          hdr_ok, hdr_bad;

   assign hdr_ok  = din[65] ^ din[64];
   assign hdr_bad = ~hdr_ok;

`ifdef BLOCK_LOCK_67_INVERT_EN
   assign payload = din[66] ? ~din[63:0] : din[63:0];
`else
   logic unused_invert;
   assign unused_invert = din[66];
   assign payload       = din[63:0];
`endif

   assign gcnt_inc = gcnt_q + 1'b1;
   assign bcnt_inc = bcnt_q + 1'b1;
   assign wcnt_inc = wcnt_q + 1'b1;
   assign ecnt_inc = ecnt_q + {{(EW-1){1'b0}}, hdr_bad};

   // Next-state and counter update; every transition is qualified by din_valid.
   always_comb begin
      state_d = state_q;
      gcnt_d  = gcnt_q;
      bcnt_d  = bcnt_q;
      wcnt_d  = wcnt_q;
      ecnt_d  = ecnt_q;
      if (din_valid) begin
         unique case (state_q)
            HUNT: begin
               if (hdr_ok) begin
                  if (gcnt_inc == LOCK_C) begin
                     state_d = LOCK;
                     gcnt_d  = '0;
                     wcnt_d  = '0;
                     ecnt_d  = '0;
                  end else begin
                     gcnt_d = gcnt_inc;
                  end
               end else begin
                  state_d = BLANK;
                  gcnt_d  = '0;
                  bcnt_d  = '0;
               end
            end
            BLANK: begin
               if (bcnt_inc == BLANK_C) begin
                  state_d = HUNT;
                  bcnt_d  = '0;
               end else begin
                  bcnt_d = bcnt_inc;
               end
            end
            LOCK: begin
               // Loss of lock takes priority over the window rollover.
               if (ecnt_inc == EMAX_C) begin
                  state_d = HUNT;
                  gcnt_d  = '0;
                  bcnt_d  = '0;
                  wcnt_d  = '0;
                  ecnt_d  = '0;
               end else if (wcnt_inc == WIN_C) begin
                  wcnt_d = '0;
                  ecnt_d = '0;
               end else begin
                  wcnt_d = wcnt_inc;
                  ecnt_d = ecnt_inc;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // Output datapath: pass words seen while already locked, zero otherwise.
   always_comb begin
      dv_d   = din_valid & (state_q == LOCK);
      dout_d = '0;
      ctl_d  = 1'b0;
      err_d  = 1'b0;
      if (dv_d) begin
         dout_d = payload;
         ctl_d  = din[65];
         err_d  = hdr_bad;
      end
   end

   // State, counters and registered outputs; status flags follow the next state.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= HUNT;
         gcnt_q   <= '0;
         bcnt_q   <= '0;
         wcnt_q   <= '0;
         ecnt_q   <= '0;
         slip_q   <= 1'b0;
         locked_q <= 1'b0;
         dout_q   <= '0;
         ctl_q    <= 1'b0;
         err_q    <= 1'b0;
         dv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         gcnt_q   <= gcnt_d;
         bcnt_q   <= bcnt_d;
         wcnt_q   <= wcnt_d;
         ecnt_q   <= ecnt_d;
         slip_q   <= (state_d == HUNT);
         locked_q <= (state_d == LOCK);
         dout_q   <= dout_d;
         ctl_q    <= ctl_d;
         err_q    <= err_d;
         dv_q     <= dv_d;
      end
   end

   assign slip_to_frame = slip_q;
   assign locked        = locked_q;
   assign dout          = dout_q;
   assign dout_ctl      = ctl_q;
   assign dout_err      = err_q;
   assign dout_valid    = dv_q;

endmodule

// File: tb/tb_block_lock_67.sv
// Bench for block_lock_67: random words with random valid gaps, compared each clock
// against a behavioural model of the lock rules (run lengths, a blanking countdown
// and per-window error tallies).
module tb_block_lock_67;

   localparam int LOCK_CNT   = 64;
   localparam int SLIP_BLANK = 4;
   localparam int ERR_WIN    = 64;
   localparam int ERR_MAX    = 16;

   localparam int M_HUNT  = 0;
   localparam int M_BLANK = 1;
   localparam int M_LOCK  = 2;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic [66:0] din = '0;
   logic        din_valid = 1'b0;
   logic        slip_to_frame, locked, dout_ctl, dout_err, dout_valid;
   logic [63:0] dout;

   int n_checks = 0;
   int n_errors = 0;

   int m_mode, m_run, m_blank_left, m_win_pos, m_win_errs;

   block_lock_67 dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .din          (din),
      .din_valid    (din_valid),
      .slip_to_frame(slip_to_frame),
      .locked       (locked),
      .dout         (dout),
      .dout_ctl     (dout_ctl),
      .dout_err     (dout_err),
      .dout_valid   (dout_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] exp_payload(input logic [66:0] w);
`ifdef BLOCK_LOCK_67_INVERT_EN
      return w[66] ? ~w[63:0] : w[63:0];
`else
      return w[63:0];
`endif
   endfunction

   task automatic model_reset();
      m_mode = M_HUNT;
      m_run = 0;
      m_blank_left = 0;
      m_win_pos = 0;
      m_win_errs = 0;
   endtask

   // One clock: present a word, then compare outputs against the model.
   task automatic step(input bit v, input logic [66:0] w);
      bit          good, e_dv;
      logic [63:0] e_dout;
      din = w;
      din_valid = v;
      @(posedge clk);
      #1;
      good   = (w[65] != w[64]);
      e_dv   = v && (m_mode == M_LOCK);
      e_dout = e_dv ? exp_payload(w) : 64'h0;
      chk("dout_valid", dout_valid, 64'(e_dv));
      chk("dout", dout, e_dout);
      chk("dout_ctl", dout_ctl, 64'(e_dv & w[65]));
      chk("dout_err", dout_err, 64'(e_dv & !good));
      if (v) begin
         case (m_mode)
            M_HUNT: begin
               if (good) begin
                  m_run++;
                  if (m_run == LOCK_CNT) begin
                     m_mode = M_LOCK;
                     m_run = 0;
                     m_win_pos = 0;
                     m_win_errs = 0;
                  end
               end else begin
                  m_run = 0;
                  m_mode = M_BLANK;
                  m_blank_left = SLIP_BLANK;
               end
            end
            M_BLANK: begin
               m_blank_left--;
               if (m_blank_left == 0) m_mode = M_HUNT;
            end
            default: begin
               m_win_pos++;
               if (!good) m_win_errs++;
               if (m_win_errs == ERR_MAX) begin
                  m_mode = M_HUNT;
                  m_run = 0;
                  m_win_pos = 0;
                  m_win_errs = 0;
               end else if (m_win_pos == ERR_WIN) begin
                  m_win_pos = 0;
                  m_win_errs = 0;
               end
            end
         endcase
      end
      chk("locked", locked, 64'(m_mode == M_LOCK));
      chk("slip_to_frame", slip_to_frame, 64'(m_mode == M_HUNT));
   endtask

   function automatic logic [66:0] mk(input bit good);
      logic [1:0] h;
      if (good) h = $urandom_range(0, 1) ? 2'b10 : 2'b01;
      else      h = $urandom_range(0, 1) ? 2'b11 : 2'b00;
      return {1'($urandom_range(0, 1)), h, $urandom, $urandom};
   endfunction

   function automatic logic [66:0] junk();
      return {3'($urandom), $urandom, $urandom};
   endfunction

   // One valid word, sometimes preceded by a few idle cycles carrying junk.
   task automatic send(input bit good);
      if ($urandom_range(0, 4) == 0)
         repeat ($urandom_range(1, 3)) step(1'b0, junk());
      step(1'b1, mk(good));
   endtask

   function automatic logic [63:0] rmask(input int k, input int lim);
      logic [63:0] m = '0;
      int cnt = 0;
      while (cnt < k) begin
         int p = $urandom_range(0, lim - 1);
         if (!m[p]) begin
            m[p] = 1'b1;
            cnt++;
         end
      end
      return m;
   endfunction

   task automatic send_window(input logic [63:0] bad_mask);
      for (int i = 0; i < ERR_WIN; i++) send(!bad_mask[i]);
   endtask

   task automatic relock();
      int guard = 0;
      while (m_mode != M_LOCK && guard < 300) begin
         send(1'b1);
         guard++;
      end
      chk("relock", locked, 64'h1);
   endtask

   task automatic mid_reset();
      #3 arst_n = 1'b0;
      #1;
      chk("rst_locked", locked, 64'h0);
      chk("rst_slip", slip_to_frame, 64'h0);
      chk("rst_dout_valid", dout_valid, 64'h0);
      chk("rst_dout", dout, 64'h0);
      chk("rst_dout_ctl", dout_ctl, 64'h0);
      chk("rst_dout_err", dout_err, 64'h0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      arst_n = 1'b1;
   endtask

   initial begin
      logic [66:0] w;
      int pct;
      model_reset();

      // Reset held: all outputs low.
      repeat (3) @(posedge clk);
      #1;
      chk("por_locked", locked, 64'h0);
      chk("por_slip", slip_to_frame, 64'h0);
      chk("por_dout_valid", dout_valid, 64'h0);
      chk("por_dout", dout, 64'h0);
      @(negedge clk);
      arst_n = 1'b1;
      step(1'b0, junk());
      chk("slip_after_release", slip_to_frame, 64'h1);

      // 63 good, one 2'b11 header, blanking, then a fresh 64-good run locks.
      for (int i = 0; i < LOCK_CNT - 1; i++) send(1'b1);
      step(1'b1, {1'b0, 2'b11, $urandom, $urandom});
      chk("blank_slip", slip_to_frame, 64'h0);
      for (int i = 0; i < SLIP_BLANK; i++) send($urandom_range(0, 1) == 1);
      chk("blank_done_slip", slip_to_frame, 64'h1);
      for (int i = 0; i < LOCK_CNT - 1; i++) send(1'b1);
      chk("not_yet_locked", locked, 64'h0);
      send(1'b1);
      chk("locked_after_64", locked, 64'h1);

      // Two windows of 15 bad; the second gets its 16th on its last word.
      send_window(rmask(15, ERR_WIN));
      chk("win_a_hold", locked, 64'h1);
      send_window(rmask(15, ERR_WIN - 1) | (64'h1 << (ERR_WIN - 1)));
      chk("loss_on_last", locked, 64'h0);
      chk("loss_on_last_slip", slip_to_frame, 64'h1);

      // Sixteen bad spread within one window.
      relock();
      send_window(rmask(ERR_MAX, ERR_WIN));
      chk("loss_16", locked, 64'h0);

      // Inverted control word with idle gaps around it.
      relock();
      step(1'b0, junk());
      w = {1'b1, 2'b10, 64'h0};
      step(1'b1, w);
`ifdef BLOCK_LOCK_67_INVERT_EN
      chk("inv_word", dout, 64'hFFFF_FFFF_FFFF_FFFF);
`else
      chk("inv_word", dout, 64'h0);
`endif
      chk("inv_word_ctl", dout_ctl, 64'h1);
      step(1'b0, junk());

      // Random soak with varying error density and one mid-run reset.
      pct = 0;
      for (int i = 0; i < 1500; i++) begin
         if (i % 150 == 0) pct = $urandom_range(0, 2) * 15;
         if (i == 700) mid_reset();
         send($urandom_range(0, 99) >= pct);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule
